// File: rtl/pipeline_stage_ctrl.sv
// Pipeline sequencing controller: per-stage load enables, bubble clears and
// valid tracking with stall/flush arbitration, debug single-step gating and a
// saturating stall-cycle counter.
module pipeline_stage_ctrl #(
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              debug_en,
  input  logic              debug_step,
  input  logic [STAGES-1:0] stall_req,
  input  logic [STAGES-1:0] flush_req,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_clr,
  output logic [STAGES-1:0] stage_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [STAGES-1:0] r_valid;
  logic              r_step_q;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_adv;
  logic [STAGES-1:0] w_st;
  logic [STAGES-1:0] w_hold;
  logic [STAGES-1:0] w_squash;
  logic [STAGES-1:0] w_valid_d;

  // Advance gate: free-running, or one cycle per debug_step rising edge.
  always_comb begin
    w_adv = !debug_en || (debug_step && !r_step_q);
  end

  // Stall/flush arbitration, scanned from the oldest stage down. An older
  // flush discards younger stalls; a stall at or above a flush defers it.
  always_comb begin
    logic flush_found;
    logic hold_acc;
    w_st        = '0;
    w_hold      = '0;
    w_squash    = '0;
    flush_found = 1'b0;
    hold_acc    = 1'b0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      w_st[i]   = stall_req[i] && r_valid[i] && !flush_found;
      hold_acc  = hold_acc || w_st[i];
      w_hold[i] = hold_acc;
      if (flush_req[i] && r_valid[i] && !hold_acc && !flush_found) begin
        flush_found = 1'b1;
      end
      // Stages 1..K load bubbles; fetch is never cleared by a flush.
      if (i >= 1) begin
        w_squash[i] = flush_found;
      end
    end
  end

  // Stage enables and bubble clears, forced during reset and idle when not advancing.
  always_comb begin
    stage_en  = '0;
    stage_clr = '0;
    if (rst) begin
      stage_clr = '1;
    end else if (w_adv) begin
      stage_en = ~w_hold;
      for (int i = 1; i < STAGES; i++) begin
        stage_clr[i] = (!w_hold[i] && w_hold[i-1]) || w_squash[i];
      end
    end
  end

  // Next-state valid bits: held stages keep, cleared stages drop, others shift.
  always_comb begin
    w_valid_d = r_valid;
    if (w_adv) begin
      w_valid_d[0] = 1'b1;
      for (int i = 1; i < STAGES; i++) begin
        if (w_hold[i]) begin
          w_valid_d[i] = r_valid[i];
        end else if (stage_clr[i]) begin
          w_valid_d[i] = 1'b0;
        end else begin
          w_valid_d[i] = r_valid[i-1];
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= '0;
      r_step_q    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_valid  <= w_valid_d;
      r_step_q <= debug_step;
      if (w_adv && (|w_st) && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
    end
  end

  assign stage_valid = r_valid;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Scoreboard bench for pipeline_stage_ctrl: the driver runs an instruction-id
// pipe model and queues expected outputs; the monitor pops and compares.
module tb_pipeline_stage_ctrl;

  localparam int S = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         debug_en = 1'b0;
  logic         debug_step = 1'b0;
  logic [S-1:0] stall_req = '0;
  logic [S-1:0] flush_req = '0;
  logic [S-1:0] stage_en, stage_clr, stage_valid;
  logic [15:0]  stall_cnt;
  logic [S-1:0] s_en, s_clr, s_valid;
  logic [2:0]   s_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stage_ctrl #(.STAGES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .stall_req(stall_req), .flush_req(flush_req), .stage_en(stage_en),
    .stage_clr(stage_clr), .stage_valid(stage_valid), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy sharing all inputs, to reach saturation quickly.
  pipeline_stage_ctrl #(.STAGES(S), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .debug_en(debug_en), .debug_step(debug_step),
    .stall_req(stall_req), .flush_req(flush_req), .stage_en(s_en),
    .stage_clr(s_clr), .stage_valid(s_valid), .stall_cnt(s_cnt)
  );

  typedef struct packed {
    logic [S-1:0] en;
    logic [S-1:0] clr;
    logic [S-1:0] valid;
    logic [15:0]  cnt;
    logic [2:0]   cnt_s;
  } exp_t;

  exp_t sb[$];

  // Model state: instruction id per stage (0 = bubble).
  int          pipe[S];
  int          next_id = 1;
  int unsigned cnt = 0;
  bit          prev_step = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at negedge, queue the expected response, advance the model.
  task automatic step(input bit r, input bit de, input bit ds,
                      input logic [S-1:0] st, input logic [S-1:0] fl);
    exp_t e;
    bit   adv;
    int   m;
    bit   is_stall;
    @(negedge clk);
    rst = r; debug_en = de; debug_step = ds; stall_req = st; flush_req = fl;
    for (int i = 0; i < S; i++) e.valid[i] = (pipe[i] != 0);
    e.cnt   = (cnt > 65535) ? 16'hffff : 16'(cnt);
    e.cnt_s = (cnt > 7) ? 3'd7 : 3'(cnt);
    e.en    = '0;
    e.clr   = '0;
    if (r) begin
      e.clr = '1;
      for (int i = 0; i < S; i++) pipe[i] = 0;
      cnt       = 0;
      prev_step = 1'b0;
    end else begin
      adv       = !de || (ds && !prev_step);
      prev_step = ds;
      if (adv) begin
        // The oldest valid stage with any request decides; stall beats flush there.
        m = -1;
        is_stall = 1'b0;
        for (int i = S - 1; i >= 0; i--) begin
          if (pipe[i] != 0 && (st[i] || fl[i])) begin
            m = i;
            is_stall = st[i];
            break;
          end
        end
        if (m >= 0 && is_stall) begin
          for (int i = 0; i < S; i++) e.en[i] = (i > m);
          if (m < S - 1) e.clr[m+1] = 1'b1;
          for (int i = S - 1; i >= m + 2; i--) pipe[i] = pipe[i-1];
          if (m < S - 1) pipe[m+1] = 0;
          cnt++;
        end else begin
          e.en = '1;
          for (int i = S - 1; i >= 1; i--) pipe[i] = pipe[i-1];
          pipe[0] = next_id++;
          for (int i = 1; i <= m; i++) begin
            e.clr[i] = 1'b1;
            pipe[i]  = 0;
          end
        end
      end
    end
    sb.push_back(e);
  endtask

  // Monitor: sample settled outputs 2 ns after the driving edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_en", 32'(stage_en), 32'(e.en));
        chk("sb_clr", 32'(stage_clr), 32'(e.clr));
        chk("sb_valid", 32'(stage_valid), 32'(e.valid));
        chk("sb_cnt", 32'(stall_cnt), 32'(e.cnt));
        chk("sb_cnt_sat", 32'(s_cnt), 32'(e.cnt_s));
      end
    end
  end

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < S; i++) pipe[i] = 0;
    step(1, 0, 0, '0, '0);
    #2 chk("rst_en", 32'(stage_en), 32'h0);
    chk("rst_clr", 32'(stage_clr), 32'h1f);
    step(1, 0, 0, '0, '0);

    // Fill
    step(0, 0, 0, '0, '0);
    #2 chk("fill_en", 32'(stage_en), 32'h1f);
    chk("fill_clr", 32'(stage_clr), 32'h0);
    free(5);
    #2 chk("fill_full", 32'(stage_valid), 32'h1f);

    // Stall at stage 2 for two cycles
    step(0, 0, 0, 5'b00100, '0);
    #2 chk("stall_en", 32'(stage_en), 32'h18);
    chk("stall_clr", 32'(stage_clr), 32'h08);
    step(0, 0, 0, 5'b00100, '0);
    free(1);
    #2 chk("stall_valid", 32'(stage_valid), 32'h07);
    chk("stall_cnt", 32'(stall_cnt), 32'd2);
    free(2);

    // Flush from stage 2
    step(0, 0, 0, '0, 5'b00100);
    #2 chk("flush_clr", 32'(stage_clr), 32'h06);
    chk("flush_en", 32'(stage_en), 32'h1f);
    free(1);
    #2 chk("flush_valid", 32'(stage_valid), 32'h19);
    free(3);

    // Flush at 3 discards a younger stall at 1
    step(0, 0, 0, 5'b00010, 5'b01000);
    #2 chk("fl_st_clr", 32'(stage_clr), 32'h0e);
    free(1);
    #2 chk("fl_st_cnt", 32'(stall_cnt), 32'd2);
    free(4);

    // Stall at 3 defers a flush at 2
    step(0, 0, 0, 5'b01000, 5'b00100);
    #2 chk("defer_clr", 32'(stage_clr), 32'h10);
    chk("defer_en", 32'(stage_en), 32'h10);
    step(0, 0, 0, '0, 5'b00100);
    #2 chk("defer_apply", 32'(stage_clr), 32'h06);
    free(4);

    // Debug single step: level held high advances exactly once
    step(0, 1, 1, '0, '0);
    #2 chk("dbg_first", 32'(stage_en), 32'h1f);
    step(0, 1, 1, '0, '0);
    #2 chk("dbg_held", 32'(stage_en), 32'h0);
    step(0, 1, 1, '0, '0);
    step(0, 1, 0, '0, '0);
    step(0, 1, 1, '0, '0);
    step(0, 0, 0, '0, '0);

    // Reset mid-fill
    step(1, 0, 0, '0, '0);
    free(2);
    step(1, 0, 0, '0, '0);
    free(1);
    #2 chk("midrst_valid", 32'(stage_valid), 32'h0);
    chk("midrst_cnt", 32'(stall_cnt), 32'd0);

    // Saturate the narrow counter with a writeback stall
    free(5);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 5'b10000, '0);
    #2 chk("sat_cnt", 32'(s_cnt), 32'd7);
    chk("wide_cnt", 32'(stall_cnt), 32'd9);

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      logic [S-1:0] st, fl;
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(0, 7) == 0);
        fl[i] = ($urandom_range(0, 9) == 0);
      end
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 1)), st, fl);
    end

    repeat (3) @(negedge clk);
    #3 chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
